// File: rtl/udp_payload_router.sv
// Ethernet/IPv4/UDP payload router: header filter, opcode dispatch to command
// triggers, and a store-and-forward payload buffer released on AXI-Stream.
module udp_payload_router #(
    parameter logic [31:0]           DEST_IP        = 32'hC0A80132,
    parameter logic [15:0]           SRC_PORT       = 16'd55555,
    parameter bit                    CHECK_SRC_PORT = 1'b1,
    parameter logic [23:0]           DATA_OP        = 24'h102030,
    parameter int unsigned           NUM_CMD        = 2,
    parameter logic [NUM_CMD*24-1:0] CMD_OPS        = {24'hF0E0D1, 24'hF0E0D0},
    parameter int unsigned           BUF_DEPTH      = 2048,
    parameter int unsigned           IDLE_SYNC      = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [NUM_CMD-1:0] cmd_trigger,
    output logic [15:0]        pkt_ok_cnt,
    output logic [15:0]        pkt_drop_cnt
);
    localparam int unsigned ADDR_W = $clog2(BUF_DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {SYNC, HDR, PAYLOAD, DISCARD} state_t;

    state_t             r_state;
    logic [5:0]         r_byte_cnt;
    logic [15:0]        r_idle_cnt;
    logic [23:0]        r_op_sr;
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [ADDR_W:0]    r_commit_ptr;
    logic               r_ovf;
    logic [NUM_CMD-1:0] r_cmd_trigger;
    logic [15:0]        r_ok_cnt;
    logic [15:0]        r_drop_cnt;
    logic [8:0]         r_mem [BUF_DEPTH];

    logic [23:0]        w_opcode;
    logic               w_field_bad;
    logic               w_data_hit;
    logic [NUM_CMD-1:0] w_cmd_sel;
    logic               w_cmd_found;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_opcode   = {r_op_sr[15:0], s_axis_tdata};
    assign w_data_hit = (w_opcode == DATA_OP);

    always_comb begin
        w_field_bad = 1'b0;
        case (r_byte_cnt)
            6'd12: w_field_bad = (s_axis_tdata != 8'h08);
            6'd13: w_field_bad = (s_axis_tdata != 8'h00);
            6'd23: w_field_bad = (s_axis_tdata != 8'h11);
            6'd30: w_field_bad = (s_axis_tdata != DEST_IP[31:24]);
            6'd31: w_field_bad = (s_axis_tdata != DEST_IP[23:16]);
            6'd32: w_field_bad = (s_axis_tdata != DEST_IP[15:8]);
            6'd33: w_field_bad = (s_axis_tdata != DEST_IP[7:0]);
            6'd34: w_field_bad = CHECK_SRC_PORT && (s_axis_tdata != SRC_PORT[15:8]);
            6'd35: w_field_bad = CHECK_SRC_PORT && (s_axis_tdata != SRC_PORT[7:0]);
            default: w_field_bad = 1'b0;
        endcase
    end

    // Only the lowest-index matching command opcode fires.
    always_comb begin
        w_cmd_sel   = '0;
        w_cmd_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CMD; i++) begin
            if (!w_cmd_found && (w_opcode == CMD_OPS[24*i +: 24])) begin
                w_cmd_sel[i] = 1'b1;
                w_cmd_found  = 1'b1;
            end
        end
    end

    assign w_full  = ((r_wr_ptr - r_rd_ptr) == FULL_LVL);
    assign w_wr_en = (r_state == PAYLOAD) && s_axis_tvalid && !r_ovf && !w_full;
    assign w_rd    = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SYNC;
            r_byte_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_op_sr       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_ovf         <= 1'b0;
            r_cmd_trigger <= '0;
            r_ok_cnt      <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_cmd_trigger <= '0;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (s_axis_tvalid) begin
                r_op_sr <= {r_op_sr[15:0], s_axis_tdata};
                if (s_axis_tlast)
                    r_byte_cnt <= '0;
                else if (r_byte_cnt != 6'd63)
                    r_byte_cnt <= r_byte_cnt + 6'd1;
            end

            case (r_state)
                SYNC: begin
                    if (s_axis_tvalid) begin
                        r_idle_cnt <= '0;
                        if (s_axis_tlast)
                            r_state <= HDR;
                    end else if (r_idle_cnt == 16'(IDLE_SYNC - 1)) begin
                        r_idle_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= HDR;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                HDR: begin
                    if (s_axis_tvalid) begin
                        if (r_byte_cnt < 6'd44) begin
                            if (s_axis_tlast) begin
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                            end else if (w_field_bad) begin
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                                r_state    <= DISCARD;
                            end
                        end else if (w_data_hit) begin
                            if (s_axis_tlast)
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                            else
                                r_state <= PAYLOAD;
                        end else if (w_cmd_found) begin
                            r_cmd_trigger <= w_cmd_sel;
                            r_state       <= s_axis_tlast ? HDR : DISCARD;
                        end else begin
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                            r_state    <= s_axis_tlast ? HDR : DISCARD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (s_axis_tvalid) begin
                        if (w_wr_en)
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        else
                            r_ovf <= 1'b1;
                        if (s_axis_tlast) begin
                            // An overflow anywhere in the packet rolls the whole packet back.
                            if (r_ovf || w_full) begin
                                r_wr_ptr   <= r_commit_ptr;
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                            end else begin
                                r_commit_ptr <= r_wr_ptr + 1'b1;
                                r_ok_cnt     <= sat_inc(r_ok_cnt);
                            end
                            r_ovf   <= 1'b0;
                            r_state <= HDR;
                        end
                    end
                end
                DISCARD: begin
                    if (s_axis_tvalid && s_axis_tlast)
                        r_state <= HDR;
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    assign m_axis_tvalid = (r_rd_ptr != r_commit_ptr);
    assign m_axis_tdata  = r_mem[r_rd_ptr[ADDR_W-1:0]][7:0];
    assign m_axis_tlast  = r_mem[r_rd_ptr[ADDR_W-1:0]][8];
    assign cmd_trigger   = r_cmd_trigger;
    assign pkt_ok_cnt    = r_ok_cnt;
    assign pkt_drop_cnt  = r_drop_cnt;
endmodule

// File: doc/udp_payload_router.md
Name: udp_payload_router

Overview:
- Parametrised successor to the RX payload extractor. It parses the byte-wide Ethernet/IPv4/UDP stream from the MAC and filters on EtherType, protocol, destination IP and (optionally) source port.
- Opcode dispatch: one market-data opcode goes to a store-and-forward payload buffer; up to NUM_CMD command opcodes each drive a trigger pulse.
- Only complete, clean packets are released on a backpressured AXI-Stream output. Overflowed or malformed packets are rolled back whole and counted.

Parameters:
- DEST_IP, 32'hC0A80132, accepted destination IPv4 address (bytes 30..33).
- SRC_PORT, 16'd55555, required UDP source port (bytes 34..35).
- CHECK_SRC_PORT, 1, 1 = enforce SRC_PORT, 0 = skip the check.
- DATA_OP, 24'h102030, market-data opcode (bytes 42..44).
- NUM_CMD, 2, number of command opcodes (1..8).
- CMD_OPS, {24'hF0E0D1,24'hF0E0D0}, NUM_CMD×24 packed; entry i is in bits [24i+23:24i].
- BUF_DEPTH, 2048, payload buffer entries (power of 2); each entry is 8 data bits plus 1 last flag.
- IDLE_SYNC, 12, idle cycles that satisfy post-reset resync.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8  RX byte from MAC.
- s_axis_tvalid  in  1  RX byte valid; no backpressure.
- s_axis_tlast  in  1  last byte of frame.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tlast  out  1  last payload byte of packet.
- cmd_trigger  out  NUM_CMD  one-cycle pulse per matched command opcode.
- pkt_ok_cnt  out  16  committed data packets, saturating.
- pkt_drop_cnt  out  16  rejected packets (filter, opcode, runt, overflow), saturating.

Behaviour:
- Reset (async, rst_n=0):
  - All pointers, counters and cmd_trigger clear to 0; m_axis_tvalid=0; state=SYNC.
  - Buffer contents are invalid after reset. Resetting mid-frame discards all partial and committed data.
- Byte counter: byte_cnt counts s_axis_tvalid beats from 0 per frame and resets to 0 after a tlast beat. Gaps in tvalid hold it.
- States:
  - SYNC: ignore input. Go to HDR after a tlast beat, or after IDLE_SYNC consecutive cycles with tvalid=0.
  - HDR (byte_cnt 0..44) checks:
    - 12/13 = 08/00.
    - 23 = 11.
    - 30..33 = DEST_IP.
    - 34..35 = SRC_PORT if CHECK_SRC_PORT.
    - 42..44 opcode against DATA_OP and every CMD_OPS entry, using a 24-bit shift register compared at byte 44.
  - Transitions at byte 44 (clean header):
    - DATA_OP match → PAYLOAD.
    - CMD_OPS[i] match → pulse cmd_trigger[i] for exactly 1 cycle (the cycle after byte 44 is sampled), then go to DISCARD.
    - If opcodes overlap, only the lowest matching index fires. DATA_OP wins over CMD_OPS.
  - Any mismatch → DISCARD with pkt_drop_cnt+1.
  - A tlast beat before byte 44 → runt: drop+1, stay in HDR.
  - PAYLOAD: each beat is written to buf[wr_ptr] with last=tlast, then wr_ptr+1.
    - On the tlast beat with no overflow: commit_ptr←wr_ptr+1, pkt_ok_cnt+1.
    - Zero-length payload (tlast at byte 44 with DATA_OP) counts as a drop.
  - Overflow: a write when wr_ptr−rd_ptr == BUF_DEPTH sets ovf. No further writes occur until tlast. At tlast: wr_ptr←commit_ptr (rollback) and drop+1.
  - DISCARD: ignore bytes until tlast, then HDR. A drop is counted exactly once per packet.
- Pointers: ADDR_W+1 bits, where ADDR_W=log2(BUF_DEPTH); the extra MSB distinguishes full from empty.
- Output:
  - m_axis_tvalid = (rd_ptr != commit_ptr); tdata/tlast = buf[rd_ptr] (asynchronous read).
  - A transfer occurs when valid&&ready; rd_ptr+1.
  - Uncommitted bytes are never visible.
  - First byte of a packet is visible the cycle after its tlast beat is sampled.
  - Simultaneous write, commit and read in one cycle is legal; the full check uses the pre-read rd_ptr (conservative).
- Counters stop at 16'hFFFF.

Test Plan:
- Clean DATA_OP frame, dst 192.168.1.50, src port 55555, payload 10 bytes 0x01..0x0A, tready=1 → tvalid rises 1 cycle after tlast; 10 bytes out with tlast on 0x0A; pkt_ok_cnt=1.
- Frame with opcode F0E0D1 → cmd_trigger=2'b10 for exactly 1 cycle after byte 44; no m_axis output; counters unchanged.
- Dest IP 192.168.1.51, or src port 1234 with CHECK_SRC_PORT=1 → no output, drop=1. Same frame with CHECK_SRC_PORT=0 and src port 1234 → accepted.
- BUF_DEPTH=64, tready=0, 40-byte packet committed, then a 40-byte packet → second rolled back; drop=1. Raise tready → exactly 40 bytes with one tlast.
- Runt frame with tlast at byte 20, then a clean frame → drop=1; clean frame delivered.
- Assert rst_n mid-payload, release at byte 100 of the same frame → remaining bytes ignored (SYNC). After tlast, the next clean frame is delivered; no output before it.
